fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 16-bit MIPS pipeline. Holds the program counter, drives the byte address into the combinational instruction memory, and captures the returned big-endian 16-bit instruction into the IF/ID pipeline register. It accepts stall requests from the hazard unit and PC redirects from branch/jump resolution, and halts on a dedicated halt encoding.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset
- MEM_BYTES, 256, instruction-memory size in bytes (power of two); the PC wraps modulo this value

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- imem_addr  out  16  byte address to instruction memory; always equals the PC
- imem_instr  in  16  instruction returned combinationally for imem_addr
- stall  in  1  hazard-unit hold request
- redirect  in  1  branch/jump taken; flush and reload the PC
- redirect_pc  in  16  target byte address; bit 0 is ignored
- ifid_instr  out  16  IF/ID instruction (16'h0000 = add $0,$0,$0 NOP)
- ifid_pc  out  16  address of ifid_instr
- ifid_pc_plus2  out  16  ifid_pc + 2, wrapped
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch is in HALT

## Operation
- The FSM has two states: RUN and HALT. halted = (state == HALT).
- The PC is always even. next_pc = (pc + 2) & (MEM_BYTES-1).
- Priority at each rising edge: redirect, then stall, then normal fetch.
- **Redirect** (either state):
  - pc <= redirect_pc & (MEM_BYTES-1) & ~1.
  - ifid_instr <= 0, ifid_valid <= 0, ifid_pc/ifid_pc_plus2 <= 0.
  - state <= RUN.
  - The wrong-path instruction is dropped.
- **Stall, no redirect**:
  - pc, all IF/ID registers and state hold.
- **RUN, normal fetch**:
  - ifid_instr <= imem_instr, ifid_pc <= pc, ifid_pc_plus2 <= next_pc, ifid_valid <= 1.
  - If imem_instr == 16'hFFFF (halt): pc holds and state <= HALT.
  - Otherwise pc <= next_pc.
- **HALT, no redirect, no stall**:
  - pc holds.
  - ifid_instr <= 0, ifid_valid <= 0 (bubbles).
  - The halt instruction itself was delivered once, with valid=1.
- Only redirect or rst leaves HALT.

## Timing
- Reset (async, immediate, also mid-operation):
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - ifid_instr = 0, ifid_pc = 0, ifid_pc_plus2 = 0, ifid_valid = 0.
  - state = RUN, halted = 0.
  - Counters are 0 when the perf feature is enabled.
- Fetch latency: the instruction at address A appears on ifid_instr exactly 1 edge after the cycle in which pc == A.
- First valid IF/ID: the first rising edge after rst deasserts captures the instruction at RESET_PC.
- Redirect latency: on the redirect edge, imem_addr = target immediately after the edge. The target instruction is valid in IF/ID at the next edge, so there is exactly one bubble.
- Throughput: one instruction per cycle while not stalled.
- Wrap-around: at pc = MEM_BYTES-2, next_pc = 0 and ifid_pc_plus2 = 0.
- Simultaneous stall and redirect: the redirect wins.
- Halt instruction fetched while stall=1: no capture and no state change until stall drops.
- All outputs are registered, except imem_addr, which is driven directly from the pc register.

## Configuration
- Macro: FETCH_PERF_CNT_EN.
- When defined, two output ports are added:
  - perf_fetch_cnt (32): increments on every edge where ifid_valid is loaded with 1.
  - perf_stall_cnt (32): increments on every edge with stall=1 and redirect=0.
  - Both counters wrap at 2^32, are cleared by rst, and have no other effect on fetch behaviour.
- When undefined, the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- **Reset and sequential fetch**: memory holds 16'h0C70 at 0 and 16'h1234 at 2; release rst. Required: edge 1 gives ifid_instr=16'h0C70, ifid_pc=0, ifid_pc_plus2=2, valid=1; edge 2 gives 16'h1234, ifid_pc=2.
- **Stall**: assert stall for 3 cycles at pc=6. Required: imem_addr stays 6 and the IF/ID contents are unchanged for 3 edges; fetch resumes at 6 on the 4th edge.
- **Redirect with simultaneous stall**: at pc=8, drive redirect=1, stall=1, redirect_pc=16'h0021. Required: imem_addr=16'h0020 after the edge, valid=0 and ifid_instr=0; the next edge gives ifid_pc=16'h0020, valid=1.
- **Halt**: place 16'hFFFF at address 10. Required: IF/ID gets 16'hFFFF with valid=1 and halted=1; imem_addr stays 10; the following edges give valid=0. A redirect to 0 returns the FSM to RUN with halted=0.
- **Wrap**: redirect to 254 with MEM_BYTES=256. Required: ifid_pc=254 and ifid_pc_plus2=0; the next fetch is from address 0.
- **Mid-operation reset**: pulse rst between clock edges while in HALT with valid=1. Required: all outputs return to their reset values immediately, without a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory address, IF/ID register, RUN/HALT FSM.
// Optional performance counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [15:0] ADDR_MASK  = 16'(MEM_BYTES - 1);
  localparam logic [15:0] HALT_INSTR = 16'hFFFF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d;
  logic [15:0] ifpc2_q, ifpc2_d;
  logic        valid_q, valid_d;

  logic [15:0] next_pc;
  logic        fetch_en;
  logic        is_halt;

  assign next_pc  = (pc_q + 16'd2) & ADDR_MASK;
  assign fetch_en = !redirect && !stall && (state_q == ST_RUN);
  assign is_halt  = (imem_instr == HALT_INSTR);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: redirect always restarts fetch; a captured halt word parks the FSM
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = ST_RUN;
    end else if (fetch_en && is_halt) begin
      state_d = ST_HALT;
    end
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ifpc_q  <= 16'h0000;
      ifpc2_q <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifpc2_q <= ifpc2_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifpc2_d = ifpc2_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = redirect_pc & ADDR_MASK & 16'hFFFE;
      instr_d = 16'h0000;
      ifpc_d  = 16'h0000;
      ifpc2_d = 16'h0000;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (state_q == ST_RUN) begin
      instr_d = imem_instr;
      ifpc_d  = pc_q;
      ifpc2_d = next_pc;
      valid_d = 1'b1;
      // The halt word is delivered once; the PC stays parked on it
      if (!is_halt) begin
        pc_d = next_pc;
      end
    end else begin
      instr_d = 16'h0000;
      valid_d = 1'b0;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ifpc_q;
  assign ifid_pc_plus2 = ifpc2_q;
  assign ifid_valid    = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_en) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall && !redirect) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
